// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader placed upstream of the single-clock MIPS core.
// It takes a byte stream (word count N, then 4N bytes, MSB first), packs the
// bytes into 32-bit instruction words and writes them to consecutive
// instruction-memory word addresses. When the last word is written it lets
// the core run; when the core reports fin it holds the core again and waits
// for a new program starting at address 0.
//
// Parameters
//   ADDR_WIDTH  instruction-memory word-address width (depth 2^ADDR_WIDTH),
//               at least 2.
//
// Ports
//   clk         system clock, rising edge
//   pcclr       asynchronous active-low reset
//   rx_valid    byte offered on rx_data
//   rx_data     byte payload
//   rx_ready    loader accepts a byte this cycle
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   word address of the write
//   imem_wdata  instruction word of the write
//   cpu_run     drives the core's active-low pcclr (1 = run)
//   cpu_fin     core's fin output
//   err         sticky overflow flag (program longer than memory)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  pcclr,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_run,
    input  logic                  cpu_fin,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_LEN   = 2'd0,
        S_BYTES = 2'd1,
        S_WRITE = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};

    state_t                state_q,    state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [7:0]            word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    // Set once the top address has been written; later words are dropped.
    logic                  full_q,     full_d;
    logic [31:0]           wdata_q,    wdata_d;
    logic                  we_q,       we_d;
    logic                  ready_q,    ready_d;
    logic                  run_q,      run_d;
    logic                  err_q,      err_d;
    logic                  xfer_s;

    // Byte transfer happens only when the registered ready meets rx_valid.
    assign xfer_s = rx_valid & ready_q;

    // Next-state and next-output logic of the loader FSM.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        full_d     = full_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        err_d      = err_q;

        case (state_q)
            S_LEN: begin
                if (xfer_s) begin
                    word_cnt_d = rx_data;
                    byte_idx_d = 2'd0;
                    if (rx_data == 8'd0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_BYTES;
                    end
                end else begin
                    state_d = S_LEN;
                end
            end

            S_BYTES: begin
                if (xfer_s) begin
                    wdata_d    = {wdata_q[23:0], rx_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                        // Words beyond the memory depth are consumed but
                        // never written; they raise the sticky error.
                        we_d    = ~full_q;
                        if (full_q) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
                    end else begin
                        state_d = S_BYTES;
                    end
                end else begin
                    state_d = S_BYTES;
                end
            end

            S_WRITE: begin
                word_cnt_d = word_cnt_q - 8'd1;
                // The address saturates at the top instead of wrapping.
                if (full_q) begin
                    addr_d = addr_q;
                end else if (addr_q == ADDR_MAX) begin
                    full_d = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
                if (word_cnt_q == 8'd1) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_BYTES;
                end
            end

            S_RUN: begin
                if (cpu_fin) begin
                    state_d = S_LEN;
                    addr_d  = ADDR_ZERO;
                    full_d  = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end

            default: begin
                state_d = S_LEN;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        ready_d = (state_d == S_LEN) || (state_d == S_BYTES);
        run_d   = (state_d == S_RUN);
    end

    // State and output registers; reset aborts any load or run at once.
    always_ff @(posedge clk or negedge pcclr) begin
        if (!pcclr) begin
            state_q    <= S_LEN;
            byte_idx_q <= 2'd0;
            word_cnt_q <= 8'd0;
            addr_q     <= ADDR_ZERO;
            full_q     <= 1'b0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            ready_q    <= 1'b0;
            run_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            full_q     <= full_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            ready_q    <= ready_d;
            run_q      <= run_d;
            err_q      <= err_d;
        end
    end

    assign rx_ready   = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_run    = run_q;
    assign err        = err_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the single-clock MIPS core. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them into instruction memory at consecutive word addresses. When the program is complete it releases the core's run/clear input, and it re-arms for a new program when the core reports `fin`. It replaces bench-side preloading of instruction memory with a synthesizable path.

## Interface
- `ADDR_WIDTH`, default 6: instruction-memory word-address width. Depth is 2^ADDR_WIDTH words.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `pcclr`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  a byte is offered on `rx_data`.
- `rx_data`  in  8  byte payload.
- `rx_ready`  out  1  the loader accepts a byte this cycle. A transfer occurs when `rx_valid & rx_ready` is high at a rising edge.
- `imem_we`  out  1  one-cycle write strobe to instruction memory.
- `imem_addr`  out  ADDR_WIDTH  word address for the write.
- `imem_wdata`  out  32  instruction word for the write.
- `cpu_run`  out  1  drives the core's active-low `pcclr`. 0 holds the core in reset; 1 runs it.
- `cpu_fin`  in  1  the core's `fin` output.
- `err`  out  1  sticky overflow flag.

## Operation
- Stream format:
  - Byte 0 is the word count N (0..255).
  - It is followed by 4N bytes, 4 bytes per word, most significant byte first (first byte lands in bits 31:24).
- States:
  - LEN: `rx_ready` = 1. An accepted byte loads the word counter with N and clears the byte index. If N = 0, go to RUN. Otherwise go to BYTES.
  - BYTES: `rx_ready` = 1. Each accepted byte shifts into the word register; the byte index increments 0→3. The 4th accepted byte moves the state to WRITE.
  - WRITE: `rx_ready` = 0. Assert `imem_we` for exactly one cycle, then:
    - increment the address;
    - decrement the word counter;
    - go to RUN if the counter reaches 0, otherwise back to BYTES.
  - RUN: `rx_ready` = 0 and `cpu_run` = 1. `cpu_fin` high at a rising edge sets `cpu_run` = 0 and the state to LEN; the address resets to 0 for the next program.
- `imem_addr` is the current write address and `imem_wdata` is the assembled word. Both are held stable while `imem_we` = 1.
- Overflow: if N > 2^ADDR_WIDTH, words at index ≥ 2^ADDR_WIDTH are still consumed, but `imem_we` stays 0 for them and `err` sets. `err` stays set until `pcclr` is asserted. The address does not wrap.
- `cpu_fin` is ignored in LEN, BYTES and WRITE.
- `rx_data` is sampled only on a transfer. Non-handshaked cycles change no state.

## Timing
- Reset values, held while `pcclr` = 0:
  - state = LEN;
  - `rx_ready` = 0 (forced low during reset, 1 from the first cycle after release);
  - `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0;
  - `cpu_run` = 0, `err` = 0;
  - byte index = 0, word counter = 0.
- Reset asserted mid-load or mid-run aborts immediately: the partial word is discarded and `cpu_run` drops asynchronously.
- Latency:
  - 4th byte of a word accepted at edge k → `imem_we` = 1 during cycle k+1 → loader ready again from edge k+2.
  - Full-rate stream: 5 cycles per word.
- `cpu_run` rises at the edge that ends the last WRITE cycle, or at the edge accepting N = 0.
- `cpu_fin` sampled at edge k → `cpu_run` = 0 and `rx_ready` = 1 after edge k.
- Back-to-back `rx_valid` with gaps is legal; the byte index holds across gaps.

## Test plan
- **Reset:** `pcclr` held 0 for 3 cycles → all outputs 0. One cycle after release, `rx_ready` = 1.
- **Two-word load:** stream 0x02, 0x20,0x08,0x00,0x05, 0x8C,0x09,0x00,0x04 → `imem_we` pulses twice: addr 0 data 0x20080005, addr 1 data 0x8C090004. `cpu_run` = 1 one cycle after the second pulse. `err` = 0.
- **Throttled source:** same stream with `rx_valid` low on alternate cycles → identical writes. No byte is duplicated or lost, and `rx_ready` = 0 in WRITE cycles.
- **Empty program:** N = 0x00 → no `imem_we`. `cpu_run` = 1 after the accepting edge.
- **Overflow** (`ADDR_WIDTH` = 2): N = 5 with 20 bytes → writes to addr 0..3 only. The 5th word is consumed with `imem_we` = 0, `err` = 1, and `cpu_run` = 1 afterwards.
- **Rerun and abort:**
  - In RUN, pulse `cpu_fin` → `cpu_run` = 0 and reload starts at addr 0.
  - Assert `pcclr` after 2 bytes of a word → all outputs reset immediately. A fresh stream reloads correctly from addr 0.
